// File: rtl/vga_sync.sv
// VGA 640x480@60 timing generator: divides the 100 MHz clock to a 25 MHz
// pixel strobe and derives x/y counters, registered syncs and frame strobe.
module vga_sync #(
   parameter int HD = 640,
   parameter int HF = 16,
   parameter int HR = 96,
   parameter int HB = 48,
   parameter int VD = 480,
   parameter int VF = 10,
   parameter int VR = 2,
   parameter int VB = 33
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       frame_start
);

   localparam logic [9:0] H_MAX  = 10'(HD + HF + HR + HB - 1);
   localparam logic [9:0] V_MAX  = 10'(VD + VF + VR + VB - 1);
   localparam logic [9:0] H_DISP = 10'(HD);
   localparam logic [9:0] V_DISP = 10'(VD);
   localparam logic [9:0] HS_BEG = 10'(HD + HF);
   localparam logic [9:0] HS_END = 10'(HD + HF + HR - 1);
   localparam logic [9:0] VS_BEG = 10'(VD + VF);
   localparam logic [9:0] VS_END = 10'(VD + VF + VR - 1);

   logic [1:0] div_q;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       tick;
   logic       h_end;
   logic       v_end;
   logic       hsync_q;
   logic       vsync_q;
   logic       p_tick_q;
   logic       fs_q;

   // tick is the edge on which counters move; p_tick shows it one clock on
   always_comb begin
      tick   = (div_q == 2'd3);
      h_end  = (h_cnt == H_MAX);
      v_end  = (v_cnt == V_MAX);
      h_next = h_cnt;
      v_next = v_cnt;
      if (tick) begin
         h_next = h_end ? 10'd0 : h_cnt + 10'd1;
         if (h_end)
            v_next = v_end ? 10'd0 : v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         div_q    <= 2'd0;
         h_cnt    <= 10'd0;
         v_cnt    <= 10'd0;
         p_tick_q <= 1'b0;
         fs_q     <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
      end else begin
         div_q    <= div_q + 2'd1;
         h_cnt    <= h_next;
         v_cnt    <= v_next;
         p_tick_q <= tick;
         fs_q     <= tick & h_end & v_end;
         // syncs track the count being loaded so they align with x/y
         hsync_q  <= ~((h_next >= HS_BEG) && (h_next <= HS_END));
         vsync_q  <= ~((v_next >= VS_BEG) && (v_next <= VS_END));
      end
   end

   assign x           = h_cnt;
   assign y           = v_cnt;
   assign p_tick      = p_tick_q;
   assign frame_start = fs_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = ~reset && (h_cnt < H_DISP) && (v_cnt < V_DISP);

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: default-size instance for line timing, a shrunken
// instance (16x12 totals) for frame-level and mid-frame reset cases.
module tb_vga_sync;

   logic       clk = 1'b0;
   logic       rst_d;
   logic       rst_s;
   logic       d_hs, d_vs, d_vo, d_pt, d_fs;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_vo, s_pt, s_fs;
   logic [9:0] s_x, s_y;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   vga_sync u_def (
      .clk_100MHz(clk), .reset(rst_d), .hsync(d_hs), .vsync(d_vs),
      .video_on(d_vo), .p_tick(d_pt), .x(d_x), .y(d_y),
      .frame_start(d_fs)
   );

   // H: 8 disp, 2 fp, 3 sync, 3 bp; V: 6 disp, 2 fp, 2 sync, 2 bp
   vga_sync #(
      .HD(8), .HF(2), .HR(3), .HB(3),
      .VD(6), .VF(2), .VR(2), .VB(2)
   ) u_small (
      .clk_100MHz(clk), .reset(rst_s), .hsync(s_hs), .vsync(s_vs),
      .video_on(s_vo), .p_tick(s_pt), .x(s_x), .y(s_y),
      .frame_start(s_fs)
   );

   typedef struct {
      int         k;
      logic [9:0] ex;
      logic [9:0] ey;
      logic       pt;
      logic       hs;
      logic       vo;
   } vec_t;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       vo;
      logic       seen;
   } vo_t;

   vec_t tbl[14];
   vo_t  vot[6];

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      int cur;
      int nfs;
      int fs_k0;
      int fs_k1;
      int vs_ticks;
      int hs_ticks;
      int pt_cnt;
      int pt_dbl;
      int xmax;
      int ymax;
      logic pt_prev;

      tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{3,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{4,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
      tbl[3]  = '{5,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{8,    10'd2,   10'd0, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{2559, 10'd639, 10'd0, 1'b0, 1'b1, 1'b1};
      tbl[6]  = '{2560, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{2623, 10'd655, 10'd0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{2624, 10'd656, 10'd0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{3007, 10'd751, 10'd0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{3008, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{3196, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{3199, 10'd799, 10'd0, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{3200, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1};

      vot[0] = '{10'd0,  10'd0,  1'b1, 1'b0};
      vot[1] = '{10'd7,  10'd5,  1'b1, 1'b0};
      vot[2] = '{10'd8,  10'd0,  1'b0, 1'b0};
      vot[3] = '{10'd15, 10'd0,  1'b0, 1'b0};
      vot[4] = '{10'd0,  10'd6,  1'b0, 1'b0};
      vot[5] = '{10'd7,  10'd11, 1'b0, 1'b0};

      rst_d = 1'b1;
      rst_s = 1'b1;
      clk_n(3);
      chk("rst x",  d_x,  0);
      chk("rst y",  d_y,  0);
      chk("rst pt", d_pt, 0);
      chk("rst hs", d_hs, 1);
      chk("rst vs", d_vs, 1);
      chk("rst fs", d_fs, 0);
      chk("rst vo", d_vo, 0);

      // default-size line walk
      rst_d = 1'b0;
      cur = 0;
      for (int i = 0; i < 14; i++) begin
         clk_n(tbl[i].k - cur);
         cur = tbl[i].k;
         chk($sformatf("v%0d x", i),  d_x,  tbl[i].ex);
         chk($sformatf("v%0d y", i),  d_y,  tbl[i].ey);
         chk($sformatf("v%0d pt", i), d_pt, tbl[i].pt);
         chk($sformatf("v%0d hs", i), d_hs, tbl[i].hs);
         chk($sformatf("v%0d vo", i), d_vo, tbl[i].vo);
         chk($sformatf("v%0d fs", i), d_fs, 0);
      end

      // pulse counts over exactly one default line
      rst_d = 1'b1;
      clk_n(1);
      rst_d = 1'b0;
      hs_ticks = 0;
      pt_cnt = 0;
      pt_dbl = 0;
      pt_prev = 1'b0;
      for (int k = 1; k <= 3200; k++) begin
         clk_n(1);
         if (d_pt) pt_cnt++;
         if (d_pt && pt_prev) pt_dbl++;
         if (d_pt && !d_hs) hs_ticks++;
         pt_prev = d_pt;
      end
      chk("line pt count", pt_cnt, 800);
      chk("pt wide", pt_dbl, 0);
      chk("hs low ticks", hs_ticks, 96);
      chk("line end y", d_y, 1);

      // small frames: frame_start period, vsync width, video_on corners
      rst_s = 1'b0;
      nfs = 0;
      fs_k0 = -1;
      fs_k1 = -1;
      vs_ticks = 0;
      xmax = 0;
      ymax = 0;
      for (int k = 1; k <= 1600; k++) begin
         clk_n(1);
         if (s_fs) begin
            if (nfs == 0) fs_k0 = k;
            if (nfs == 1) fs_k1 = k;
            nfs++;
         end
         if (k <= 768 && s_pt && !s_vs) vs_ticks++;
         if (!s_vs && s_y != 10'd8 && s_y != 10'd9) vs_ticks += 1000;
         if (int'(s_x) > xmax) xmax = int'(s_x);
         if (int'(s_y) > ymax) ymax = int'(s_y);
         for (int j = 0; j < 6; j++)
            if (!vot[j].seen && s_x == vot[j].x && s_y == vot[j].y) begin
               vot[j].seen = 1'b1;
               chk($sformatf("vo %0d,%0d", vot[j].x, vot[j].y),
                   s_vo, vot[j].vo);
            end
      end
      for (int j = 0; j < 6; j++)
         if (!vot[j].seen) begin
            nerr++;
            $display("FAIL vo point %0d never reached", j);
         end
      chk("fs count", nfs, 2);
      chk("fs first", fs_k0, 768);
      chk("fs period", fs_k1 - fs_k0, 768);
      chk("vs low ticks", vs_ticks, 32);
      chk("x max", xmax, 15);
      chk("y max", ymax, 11);

      // one-clock reset mid-frame at (5,3)
      rst_s = 1'b1;
      clk_n(1);
      rst_s = 1'b0;
      clk_n(212);
      chk("mid x", s_x, 5);
      chk("mid y", s_y, 3);
      rst_s = 1'b1;
      clk_n(1);
      chk("mr x",  s_x,  0);
      chk("mr y",  s_y,  0);
      chk("mr hs", s_hs, 1);
      chk("mr vs", s_vs, 1);
      chk("mr pt", s_pt, 0);
      chk("mr vo", s_vo, 0);
      rst_s = 1'b0;
      clk_n(3);
      chk("mr3 pt", s_pt, 0);
      chk("mr3 x",  s_x,  0);
      clk_n(1);
      chk("mr4 pt", s_pt, 1);
      chk("mr4 x",  s_x,  1);

      // reset while both syncs are low at (11,9)
      rst_s = 1'b1;
      clk_n(1);
      rst_s = 1'b0;
      clk_n(620);
      chk("sl x",  s_x,  11);
      chk("sl y",  s_y,  9);
      chk("sl hs", s_hs, 0);
      chk("sl vs", s_vs, 0);
      rst_s = 1'b1;
      clk_n(1);
      chk("sr hs", s_hs, 1);
      chk("sr vs", s_vs, 1);
      chk("sr fs", s_fs, 0);
      rst_s = 1'b0;
      nfs = 0;
      for (int k = 1; k <= 767; k++) begin
         clk_n(1);
         if (s_fs) nfs++;
      end
      chk("no early fs", nfs, 0);
      clk_n(1);
      chk("fs after rst", s_fs, 1);
      chk("fs x", s_x, 0);
      chk("fs y", s_y, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
